// File: rtl/pipeline_pkg.sv
// Shared definitions for the chroma-key pipeline configuration path.
//   - Command opcodes accepted on the MCU/SPI byte stream
//   - Command-parser FSM state type
//   - Default pass thresholds used by the chroma-key stage after reset
package pipeline_pkg;

   localparam logic [7:0] OP_CLEAR      = 8'h00;
   localparam logic [7:0] OP_SET_ENABLE = 8'h01;
   localparam logic [7:0] OP_SET_THRESH = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG0 = 2'd1,
      ST_ARG1 = 2'd2,
      ST_ARG2 = 2'd3
   } key_state_e;

   localparam int unsigned DEF_RED_PASS   = 4;
   localparam int unsigned DEF_GREEN_PASS = 44;
   localparam int unsigned DEF_BLUE_PASS  = 12;

endpackage

// File: rtl/pipeline_key_config.sv
// Command-driven configuration controller for the chroma-key compositing stage.
// Byte commands stage key-enable / threshold values in shadow registers, and
// the shadow is committed atomically to the outputs on frame_start.
//
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   cmd_valid     - command byte valid
//   cmd_data      - command byte
//   cmd_ready     - byte accepted when cmd_valid && cmd_ready
//   frame_start   - one-cycle pulse at start of frame (commit point)
//   key_enable    - committed chroma-key enable
//   red_pass      - committed red maximum
//   green_pass    - committed green minimum
//   blue_pass     - committed blue maximum
//   pending       - uncommitted shadow write exists
//   cmd_error     - sticky error (unknown opcode or inter-byte timeout)
module pipeline_key_config
   import pipeline_pkg::*;
#(
   parameter int unsigned                RED_SIZE    = 5,
   parameter int unsigned                GREEN_SIZE  = 6,
   parameter int unsigned                BLUE_SIZE   = 5,
   parameter logic [RED_SIZE-1:0]        RED_RESET   = RED_SIZE'(DEF_RED_PASS),
   parameter logic [GREEN_SIZE-1:0]      GREEN_RESET = GREEN_SIZE'(DEF_GREEN_PASS),
   parameter logic [BLUE_SIZE-1:0]       BLUE_RESET  = BLUE_SIZE'(DEF_BLUE_PASS),
   parameter int unsigned                TIMEOUT     = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   input  logic [7:0]            cmd_data,
   output logic                  cmd_ready,
   input  logic                  frame_start,
   output logic                  key_enable,
   output logic [RED_SIZE-1:0]   red_pass,
   output logic [GREEN_SIZE-1:0] green_pass,
   output logic [BLUE_SIZE-1:0]  blue_pass,
   output logic                  pending,
   output logic                  cmd_error
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   key_state_e            state_q, state_d;
   logic                  is_thresh_q, is_thresh_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ready_q;

   logic [RED_SIZE-1:0]   stage_red_q;
   logic [GREEN_SIZE-1:0] stage_green_q;

   logic                  shadow_en_q;
   logic [RED_SIZE-1:0]   shadow_red_q;
   logic [GREEN_SIZE-1:0] shadow_green_q;
   logic [BLUE_SIZE-1:0]  shadow_blue_q;

   logic                  pending_q;
   logic                  error_q;

   logic accept;
   logic timeout_hit;
   logic en_wr, th_wr;
   logic red_ld, green_ld;
   logic err_set, err_clr;

   assign accept    = cmd_valid && ready_q;
   assign cmd_ready = ready_q;
   assign pending   = pending_q;
   assign cmd_error = error_q;

   // Parser decode: one byte per cycle, no bubbles between commands.
   always_comb begin
      state_d     = state_q;
      is_thresh_d = is_thresh_q;
      en_wr       = 1'b0;
      th_wr       = 1'b0;
      red_ld      = 1'b0;
      green_ld    = 1'b0;
      err_set     = 1'b0;
      err_clr     = 1'b0;
      // An accepted byte always beats a timeout landing in the same cycle.
      timeout_hit = (state_q != ST_IDLE) && !accept && (cnt_q == CNT_LAST);

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               case (cmd_data)
                  OP_CLEAR:      err_clr = 1'b1;
                  OP_SET_ENABLE: begin
                     state_d     = ST_ARG0;
                     is_thresh_d = 1'b0;
                  end
                  OP_SET_THRESH: begin
                     state_d     = ST_ARG0;
                     is_thresh_d = 1'b1;
                  end
                  default:       err_set = 1'b1;
               endcase
            end
            ST_ARG0: begin
               if (is_thresh_q) begin
                  red_ld  = 1'b1;
                  state_d = ST_ARG1;
               end else begin
                  en_wr   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_ARG1: begin
               green_ld = 1'b1;
               state_d  = ST_ARG2;
            end
            ST_ARG2: begin
               th_wr   = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (timeout_hit) begin
         // Staging values are simply abandoned; they only reach the shadow
         // after a full three-byte payload, so no clearing is needed.
         err_set = 1'b1;
         state_d = ST_IDLE;
      end

      if (accept || timeout_hit || (state_q == ST_IDLE)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         is_thresh_q <= 1'b0;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_thresh_q <= is_thresh_d;
         cnt_q       <= cnt_d;
         ready_q     <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_red_q   <= '0;
         stage_green_q <= '0;
      end else begin
         if (red_ld)   stage_red_q   <= cmd_data[RED_SIZE-1:0];
         if (green_ld) stage_green_q <= cmd_data[GREEN_SIZE-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_en_q    <= 1'b0;
         shadow_red_q   <= RED_RESET;
         shadow_green_q <= GREEN_RESET;
         shadow_blue_q  <= BLUE_RESET;
      end else begin
         if (en_wr) shadow_en_q <= cmd_data[0];
         if (th_wr) begin
            shadow_red_q   <= stage_red_q;
            shadow_green_q <= stage_green_q;
            shadow_blue_q  <= cmd_data[BLUE_SIZE-1:0];
         end
      end
   end

   // Commit samples the shadow as it stood before this cycle's write, so a
   // write coinciding with frame_start stays pending for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_enable <= 1'b0;
         red_pass   <= RED_RESET;
         green_pass <= GREEN_RESET;
         blue_pass  <= BLUE_RESET;
      end else if (frame_start && pending_q) begin
         key_enable <= shadow_en_q;
         red_pass   <= shadow_red_q;
         green_pass <= shadow_green_q;
         blue_pass  <= shadow_blue_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
      end else if (en_wr || th_wr) begin
         pending_q <= 1'b1;
      end else if (frame_start) begin
         pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else if (err_set) begin
         error_q <= 1'b1;
      end else if (err_clr) begin
         error_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_key_config.sv
// Directed testbench for pipeline_key_config: command parsing, frame-start
// commit, timeout, error flag, simultaneous events and mid-command reset.
module tb_pipeline_key_config;

   localparam int unsigned TIMEOUT = 1024;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       frame_start;
   logic       key_enable;
   logic [4:0] red_pass;
   logic [5:0] green_pass;
   logic [4:0] blue_pass;
   logic       pending;
   logic       cmd_error;

   int n_checks;
   int n_fail;

   pipeline_key_config #(
      .RED_SIZE   (5),
      .GREEN_SIZE (6),
      .BLUE_SIZE  (5),
      .RED_RESET  (5'd4),
      .GREEN_RESET(6'd44),
      .BLUE_RESET (5'd12),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_data   (cmd_data),
      .cmd_ready  (cmd_ready),
      .frame_start(frame_start),
      .key_enable (key_enable),
      .red_pass   (red_pass),
      .green_pass (green_pass),
      .blue_pass  (blue_pass),
      .pending    (pending),
      .cmd_error  (cmd_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic check_thresh(input string tag, input int r, input int g,
                               input int b);
      check_value({tag, "_red"},   32'(red_pass),   32'(r));
      check_value({tag, "_green"}, 32'(green_pass), 32'(g));
      check_value({tag, "_blue"},  32'(blue_pass),  32'(b));
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_byte_frame(input logic [7:0] b);
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_data    = b;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_data    = 8'h00;
      frame_start = 1'b0;

      // Reset values and ready timing
      repeat (3) @(negedge clk);
      check_value("rst_ready",   32'(cmd_ready),  0);
      check_value("rst_enable",  32'(key_enable), 0);
      check_value("rst_pending", 32'(pending),    0);
      check_value("rst_error",   32'(cmd_error),  0);
      check_thresh("rst", 4, 44, 12);
      rst_n = 1'b1;
      #1;
      check_value("ready_first_cycle", 32'(cmd_ready), 0);
      @(posedge clk);
      #1;
      check_value("ready_second_cycle", 32'(cmd_ready), 1);
      repeat (10) @(posedge clk);
      #1;
      check_value("idle_enable",  32'(key_enable), 0);
      check_value("idle_pending", 32'(pending),    0);
      check_value("idle_error",   32'(cmd_error),  0);
      check_value("idle_ready",   32'(cmd_ready),  1);
      check_thresh("idle", 4, 44, 12);

      // Staged thresholds/enable hold until frame_start
      send_byte(8'h02); send_byte(8'h03); send_byte(8'h30);
      check_value("thresh_partial_pending", 32'(pending), 0);
      send_byte(8'h08);
      check_value("thresh_pending", 32'(pending), 1);
      send_byte(8'h01); send_byte(8'h01);
      check_value("pre_commit_enable", 32'(key_enable), 0);
      check_thresh("pre_commit", 4, 44, 12);
      pulse_frame();
      check_value("commit_enable",  32'(key_enable), 1);
      check_value("commit_pending", 32'(pending),    0);
      check_thresh("commit", 3, 48, 8);

      // Timeout on a truncated SET_THRESH
      apply_reset();
      send_byte(8'h02); send_byte(8'h05); send_byte(8'h20);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      check_value("timeout_minus1_error", 32'(cmd_error), 0);
      @(posedge clk);
      #1;
      check_value("timeout_error",   32'(cmd_error), 1);
      check_value("timeout_pending", 32'(pending),   0);
      pulse_frame();
      check_thresh("timeout_commit", 4, 44, 12);
      send_byte(8'h00);
      check_value("clear_error", 32'(cmd_error), 0);
      send_byte(8'h01); send_byte(8'h01);
      pulse_frame();
      check_value("after_timeout_enable", 32'(key_enable), 1);

      // Shadow write coinciding with frame_start
      apply_reset();
      send_byte(8'h01);
      send_byte_frame(8'h01);
      check_value("coincide_enable",  32'(key_enable), 0);
      check_value("coincide_pending", 32'(pending),    1);
      pulse_frame();
      check_value("next_frame_enable",  32'(key_enable), 1);
      check_value("next_frame_pending", 32'(pending),    0);

      // Unknown opcode, then fresh opcode parse
      send_byte(8'h7F);
      check_value("unknown_error",   32'(cmd_error),  1);
      check_value("unknown_pending", 32'(pending),    0);
      check_value("unknown_enable",  32'(key_enable), 1);
      send_byte(8'h01); send_byte(8'h00);
      check_value("fresh_pending", 32'(pending),   1);
      check_value("sticky_error",  32'(cmd_error), 1);
      pulse_frame();
      check_value("fresh_enable", 32'(key_enable), 0);
      send_byte(8'h00);
      check_value("clear_error2", 32'(cmd_error), 0);

      // Reset in the middle of a command
      send_byte(8'h01); send_byte(8'h01);
      send_byte(8'h02); send_byte(8'h11);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_value("midreset_ready",   32'(cmd_ready), 0);
      check_value("midreset_pending", 32'(pending),   0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_byte(8'h01); send_byte(8'h01);
      pulse_frame();
      check_value("midreset_enable", 32'(key_enable), 1);
      check_thresh("midreset", 4, 44, 12);

      // frame_start mid-command does not disturb parsing
      send_byte(8'h02); send_byte(8'h0A);
      pulse_frame();
      check_value("midcmd_pending", 32'(pending), 0);
      check_thresh("midcmd_hold", 4, 44, 12);
      send_byte(8'h0B); send_byte(8'h0C);
      check_value("midcmd_done_pending", 32'(pending), 1);
      pulse_frame();
      check_thresh("midcmd_commit", 10, 11, 12);

      // Upper payload bits ignored
      send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      pulse_frame();
      check_thresh("upper_bits", 31, 63, 31);

      // Mid-command frame_start commits the pending shadow
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h01);
      pulse_frame();
      check_value("midcmd_commit_enable", 32'(key_enable), 0);
      check_thresh("midcmd_commit_old", 31, 63, 31);
      send_byte(8'h02); send_byte(8'h03);
      pulse_frame();
      check_thresh("midcmd_commit_new", 1, 2, 3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
